// File: rtl/serial_alu32.sv
// serial_alu32: bit-serial WIDTH-bit ALU sequencer with an internal one-bit slice.
// One operation takes WIDTH RUN cycles (LSB first), followed by a single DONE cycle.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   start     request; accepted in IDLE or DONE
//   A, B      operands, captured on an accepted start
//   control   op code: 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR, 0/1 invalid
//   busy      high while the RUN phase is in progress
//   done      one-cycle pulse when out/flags become valid
//   out       result, held until the next operation completes
//   carryout  carry out of the MSB (arithmetic ops only)
//   overflow  signed overflow (arithmetic ops only)
//   zero      out == 0
module serial_alu32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   localparam logic [2:0] OpAdd = 3'd2;
   localparam logic [2:0] OpSub = 3'd3;
   localparam logic [2:0] OpAnd = 3'd4;
   localparam logic [2:0] OpOr  = 3'd5;
   localparam logic [2:0] OpNor = 3'd6;
   localparam logic [2:0] OpXor = 3'd7;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   // Partial result: upper WIDTH-1 bits collected so far, filled from the MSB end.
   logic [WIDTH-2:0] res_q, res_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic             arith;
   logic             b_eff;
   logic             slice_bit, slice_cout;
   logic [WIDTH-1:0] result_full;

   // One-bit ALU slice
   always_comb begin
      arith      = (ctrl_q == OpAdd) || (ctrl_q == OpSub);
      b_eff      = (ctrl_q == OpSub) ? ~b_q[0] : b_q[0];
      slice_bit  = 1'b0;
      slice_cout = 1'b0;
      case (ctrl_q)
         OpAdd, OpSub: begin
            slice_bit  = a_q[0] ^ b_eff ^ carry_q;
            slice_cout = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
         end
         OpAnd:   slice_bit = a_q[0] & b_q[0];
         OpOr:    slice_bit = a_q[0] | b_q[0];
         OpNor:   slice_bit = ~(a_q[0] | b_q[0]);
         OpXor:   slice_bit = a_q[0] ^ b_q[0];
         default: slice_bit = 1'b0;
      endcase
      result_full = {slice_bit, res_q};
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      res_d   = res_q;
      out_d   = out_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               ctrl_d  = control;
               cnt_d   = '0;
               carry_d = (control == OpSub);
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = result_full[WIDTH-1:1];
            carry_d = slice_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
               state_d = StDone;
               out_d   = result_full;
               cout_d  = arith & slice_cout;
               // carry_q is the carry into the MSB during this last bit
               ovf_d   = arith & (carry_q ^ slice_cout);
               zero_d  = (result_full == '0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign out      = out_q;
   assign carryout = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu32.sv
// Scoreboard bench for serial_alu32: the driver pushes expected results, a monitor pops
// and compares them whenever done pulses.
module tb_serial_alu32;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [2:0]   control = '0;
   logic         busy, done, carryout, overflow, zero;
   logic [W-1:0] out;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [W-1:0] out;
      logic         co;
      logic         ov;
      logic         z;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];

   serial_alu32 #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .A        (A),
      .B        (B),
      .control  (control),
      .busy     (busy),
      .done     (done),
      .out      (out),
      .carryout (carryout),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
   endtask

   function automatic exp_t mk(input logic [W-1:0] o, input logic co, input logic ov,
                               input logic z);
      exp_t e;
      e.out = o; e.co = co; e.ov = ov; e.z = z; e.cyc = 0;
      return e;
   endfunction

   // Reference model from whole-word arithmetic
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] c);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         co, ov;
      co = 1'b0; ov = 1'b0; r = '0;
      case (c)
         3'd2: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0]; co = s[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd3: begin
            s  = {1'b0, a} + {1'b0, ~b} + 1;
            r  = s[W-1:0]; co = s[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = ~(a | b);
         3'd7: r = a ^ b;
         default: r = '0;
      endcase
      return mk(r, co, ov, r == '0);
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (reset && done) begin
         chk("busy_low_in_done", {31'b0, busy}, '0);
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out", out, e.out);
            chk("carryout", {31'b0, carryout}, {31'b0, e.co});
            chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
            chk("zero", {31'b0, zero}, {31'b0, e.z});
            chk("done_cycle", W'(cyc), W'(e.cyc));
         end
      end
   end

   // Called at a negedge; returns one negedge later with start dropped.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                        input exp_t e);
      A = a; B = b; control = c; start = 1'b1;
      e.cyc = cyc + W + 1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      // captured copies must be used from here on
      A = $urandom; B = $urandom; control = 3'($urandom);
   endtask

   task automatic wait_done(input bit noise);
      for (int i = 0; i < W + 10; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
         if (noise) begin
            A = $urandom; B = $urandom; control = 3'($urandom);
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      start = 1'b0;
      chk("done_timeout_pending", W'(exp_q.size()), '0);
      @(negedge clk);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                      input exp_t e);
      issue(a, b, c, e);
      wait_done(1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rc;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, '0);
      chk("rst_done", {31'b0, done}, '0);
      chk("rst_out", out, '0);
      chk("rst_carryout", {31'b0, carryout}, '0);
      chk("rst_overflow", {31'b0, overflow}, '0);
      chk("rst_zero", {31'b0, zero}, 1);
      reset = 1'b1;
      @(negedge clk);

      run(32'd5, 32'd3, 3'd2, mk(32'h8, 0, 0, 0));
      run(32'd3, 32'd5, 3'd3, mk(32'hFFFF_FFFE, 0, 0, 0));
      run(32'h1234, 32'h1234, 3'd3, mk(32'h0, 1, 0, 1));
      run(32'h7FFF_FFFF, 32'd1, 3'd2, mk(32'h8000_0000, 0, 1, 0));
      run(32'hFFFF_FFFF, 32'd1, 3'd2, mk(32'h0, 1, 0, 1));
      run(32'hF0F0_A5A5, 32'hFF00_FFFF, 3'd4, mk(32'hF000_A5A5, 0, 0, 0));
      run(32'hF0F0_A5A5, 32'hFF00_FFFF, 3'd5, mk(32'hFFF0_FFFF, 0, 0, 0));
      run(32'hF0F0_A5A5, 32'hFF00_FFFF, 3'd6, mk(32'h000F_0000, 0, 0, 0));
      run(32'hF0F0_A5A5, 32'hFF00_FFFF, 3'd7, mk(32'h0FF0_5A5A, 0, 0, 0));
      run(32'hDEAD_BEEF, 32'h1234_5678, 3'd0, mk(32'h0, 0, 0, 1));
      run(32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd1, mk(32'h0, 0, 0, 1));

      // start pulsed mid-run is ignored
      issue(32'd5, 32'd3, 3'd2, mk(32'h8, 0, 0, 0));
      repeat (8) @(negedge clk);
      A = 32'h1111_1111; B = 32'h2222_2222; control = 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b0);

      // reset during a run aborts with no done pulse
      issue(32'h1357_9BDF, 32'h0246_8ACE, 3'd2, model(32'h1357_9BDF, 32'h0246_8ACE, 3'd2));
      repeat (14) @(negedge clk);
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk("abort_busy", {31'b0, busy}, '0);
      chk("abort_done", {31'b0, done}, '0);
      chk("abort_out", out, '0);
      chk("abort_carryout", {31'b0, carryout}, '0);
      chk("abort_zero", {31'b0, zero}, 1);
      @(negedge clk);
      reset = 1'b1;
      repeat (W + 5) @(negedge clk);
      chk("abort_out_after", out, '0);

      // start held in DONE launches the next run immediately
      issue(32'd100, 32'd58, 3'd3, mk(32'd42, 1, 0, 0));
      repeat (W) @(negedge clk);
      issue(32'hAAAA_0000, 32'h0000_5555, 3'd5, mk(32'hAAAA_5555, 0, 0, 0));
      #1;
      chk("b2b_busy", {31'b0, busy}, 1);
      chk("b2b_done", {31'b0, done}, '0);
      wait_done(1'b0);

      // randomized ops with noise on inputs and spurious start while busy
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
         rc = 3'($urandom_range(0, 7));
         issue(ra, rb, rc, model(ra, rb, rc));
         wait_done(1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
